width_arb2: RTL and testbench

- Two-requester round-robin arbiter sharing one 32-bit result bus between a 16-bit source (A) and a 25-bit source (B).
- Each granted word is widened to the bus width, by zero-extension by default. Widening and arbitration happen in the same cycle; the result is registered.
- Sits between narrow producers and a single wide consumer. It sequences the 16->25->32 widening path as one shared, handshaked resource.

---
 rtl/width_arb_pkg.sv | 33 +++
 rtl/width_arb2_rr_pick2.sv | 23 ++
 rtl/width_arb2.sv | 83 ++++++++
 tb/tb_width_arb2.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/width_arb_pkg.sv
// Shared constants and the source-to-bus widening helper for width_arb2.
// Build option WIDTH_ARB_SIGN_EXT_EN switches widen() from zero- to sign-extension.
package width_arb_pkg;

    localparam logic SRC_A = 1'b0;
    localparam logic SRC_B = 1'b1;

    localparam int W_OUT_DEF = 32;
    localparam int CNT_W_DEF = 16;

    // Widest bus widen() can produce; callers size-cast the result down to their bus.
    localparam int MAX_W = 64;

    // Extends the low w_in bits of data to MAX_W bits.
    function automatic logic [MAX_W-1:0] widen(input logic [MAX_W-1:0] data,
                                               input int w_in);
        logic [MAX_W-1:0] res;
        logic             fill;
`ifdef WIDTH_ARB_SIGN_EXT_EN
        logic [5:0]       msb;
        msb  = 6'(w_in - 1);
        fill = data[msb];
`else
        fill = 1'b0;
`endif
        res = '0;
        for (int i = 0; i < MAX_W; i++) begin
            res[i] = (i < w_in) ? data[i] : fill;
        end
        return res;
    endfunction

endpackage

// File: rtl/width_arb2_rr_pick2.sv
// Two-way round-robin picker: purely combinational; the priority register lives in the caller.
// req[0] is source A, req[1] is source B; prio names the favoured source on a tie.
module rr_pick2
    import width_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       prio,
    output logic       grant,
    output logic       gnt_valid
);

    always_comb begin
        grant     = SRC_A;
        gnt_valid = |req;
        case (req)
            2'b01:   grant = SRC_A;
            2'b10:   grant = SRC_B;
            2'b11:   grant = prio;
            default: grant = SRC_A;
        endcase
    end

endmodule

// File: rtl/width_arb2.sv
// Round-robin arbiter sharing one registered W_OUT-bit bus between a W_A and a W_B source.
// Define WIDTH_ARB_SIGN_EXT_EN to sign-extend granted words instead of zero-extending them.
module width_arb2
    import width_arb_pkg::*;
#(
    parameter int W_A   = 16,
    parameter int W_B   = 25,
    parameter int W_OUT = W_OUT_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             a_valid,
    output logic             a_ready,
    input  logic [W_A-1:0]   a_data,
    input  logic             b_valid,
    output logic             b_ready,
    input  logic [W_B-1:0]   b_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W_OUT-1:0] out_data,
    output logic             out_src,
    output logic [CNT_W-1:0] cnt_a,
    output logic [CNT_W-1:0] cnt_b
);

    if (W_A > W_OUT || W_B > W_OUT || W_OUT > MAX_W) begin : g_bad_width
        $fatal(1, "width_arb2: W_A/W_B must not exceed W_OUT, W_OUT must not exceed MAX_W");
    end

    logic             prio;
    logic             grant;
    logic             gnt_valid;
    logic             can_load;
    logic             accept;
    logic [W_OUT-1:0] wide_a;
    logic [W_OUT-1:0] wide_b;

    rr_pick2 u_pick (
        .req       ({b_valid, a_valid}),
        .prio      (prio),
        .grant     (grant),
        .gnt_valid (gnt_valid)
    );

    // Handshake: a word moves on any rising edge where its valid and ready are both high.
    // Producers hold valid and data until that edge; the output register loads when it
    // is empty or being drained on the same edge, so a held out_ready gives 1 word/cycle.
    assign can_load = !out_valid || out_ready;
    assign accept   = rst_n && can_load && gnt_valid;
    assign a_ready  = accept && (grant == SRC_A);
    assign b_ready  = accept && (grant == SRC_B);

    assign wide_a = W_OUT'(widen(MAX_W'(a_data), W_A));
    assign wide_b = W_OUT'(widen(MAX_W'(b_data), W_B));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= SRC_A;
            cnt_a     <= '0;
            cnt_b     <= '0;
            prio      <= SRC_A;
        end else begin
            if (accept) begin
                out_valid <= 1'b1;
                out_src   <= grant;
                out_data  <= (grant == SRC_B) ? wide_b : wide_a;
                // The loser of this grant is favoured next time both sources ask.
                prio      <= ~grant;
                if (grant == SRC_A) begin
                    cnt_a <= cnt_a + 1'b1;
                end else begin
                    cnt_b <= cnt_b + 1'b1;
                end
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_width_arb2.sv
// Randomised self-checking bench for width_arb2 against a transaction-level reference model.
// A second instance with CNT_W=4 exercises counter wrap on the same stimulus.
module tb_width_arb2;

    logic        clk;
    logic        rst_n;
    logic        a_valid, b_valid, out_ready;
    logic [15:0] a_data;
    logic [24:0] b_data;
    logic        a_ready, b_ready, out_valid, out_src;
    logic [31:0] out_data;
    logic [15:0] cnt_a, cnt_b;
    logic        a_ready4, b_ready4, out_valid4, out_src4;
    logic [31:0] out_data4;
    logic [3:0]  cnt_a4, cnt_b4;

    int n_checks = 0;
    int n_fail   = 0;

    width_arb2 u_dut (
        .clk(clk), .rst_n(rst_n),
        .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data),
        .b_valid(b_valid), .b_ready(b_ready), .b_data(b_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_src(out_src), .cnt_a(cnt_a), .cnt_b(cnt_b)
    );

    width_arb2 #(.CNT_W(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n),
        .a_valid(a_valid), .a_ready(a_ready4), .a_data(a_data),
        .b_valid(b_valid), .b_ready(b_ready4), .b_data(b_data),
        .out_valid(out_valid4), .out_ready(out_ready), .out_data(out_data4),
        .out_src(out_src4), .cnt_a(cnt_a4), .cnt_b(cnt_b4)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic        a_pend, b_pend;
    logic [15:0] a_word;
    logic [24:0] b_word;
    bit          m_valid;
    bit          m_src;
    logic [31:0] m_data;
    int          m_cnt_a, m_cnt_b;
    bit          m_last_b;
    logic [32:0] exp_q[$];

    function automatic logic [31:0] wa(input logic [15:0] d);
`ifdef WIDTH_ARB_SIGN_EXT_EN
        return 32'($signed(d));
`else
        return {16'h0000, d};
`endif
    endfunction

    function automatic logic [31:0] wb(input logic [24:0] d);
`ifdef WIDTH_ARB_SIGN_EXT_EN
        return 32'($signed(d));
`else
        return {7'h00, d};
`endif
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic present_a(input logic [15:0] d);
        if (!a_pend) begin
            a_pend = 1'b1;
            a_word = d;
        end
    endtask

    task automatic present_b(input logic [24:0] d);
        if (!b_pend) begin
            b_pend = 1'b1;
            b_word = d;
        end
    endtask

    task automatic do_reset(input int cycles);
        rst_n     = 1'b0;
        a_valid   = 1'b1;
        b_valid   = 1'b1;
        out_ready = 1'b1;
        repeat (cycles) @(posedge clk);
        @(negedge clk);
        #1;
        check("rst_a_ready", 64'(a_ready), 64'(0));
        check("rst_b_ready", 64'(b_ready), 64'(0));
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_out_data", 64'(out_data), 64'(0));
        check("rst_out_src", 64'(out_src), 64'(0));
        check("rst_cnt_a", 64'(cnt_a), 64'(0));
        check("rst_cnt_b", 64'(cnt_b), 64'(0));
        check("rst_cnt_a4", 64'(cnt_a4), 64'(0));
        a_pend = 1'b0; b_pend = 1'b0;
        a_valid = 1'b0; b_valid = 1'b0;
        m_valid = 1'b0; m_src = 1'b0; m_data = '0;
        m_cnt_a = 0; m_cnt_b = 0;
        m_last_b = 1'b1;      // nothing granted yet: A is favoured
        exp_q.delete();
        rst_n = 1'b1;
    endtask

    // One clock: check readies, advance model at the edge, check registered outputs.
    task automatic run_cycle(input bit rdy);
        bit          can, win_b, exp_ar, exp_br;
        logic [31:0] obs_data;
        logic        obs_src;
        logic [32:0] exp_w;
        a_valid = a_pend; a_data = a_word;
        b_valid = b_pend; b_data = b_word;
        out_ready = rdy;
        #1;
        can    = !m_valid || rdy;
        win_b  = b_pend && !(a_pend && m_last_b);
        exp_ar = can && a_pend && !win_b;
        exp_br = can && win_b;
        check("a_ready", 64'(a_ready), 64'(exp_ar));
        check("b_ready", 64'(b_ready), 64'(exp_br));
        check("a_ready4", 64'(a_ready4), 64'(exp_ar));
        check("b_ready4", 64'(b_ready4), 64'(exp_br));
        obs_data = out_data;
        obs_src  = out_src;
        @(posedge clk);
        if (m_valid && rdy) begin
            if (exp_q.size() == 0) begin
                check("drain_empty_q", 64'(1), 64'(0));
            end else begin
                exp_w = exp_q.pop_front();
                check("drain_word", 64'({obs_src, obs_data}), 64'(exp_w));
            end
        end
        if (exp_ar || exp_br) begin
            m_valid  = 1'b1;
            m_src    = win_b;
            m_data   = win_b ? wb(b_word) : wa(a_word);
            m_last_b = win_b;
            exp_q.push_back({m_src, m_data});
            if (win_b) begin
                m_cnt_b++; b_pend = 1'b0;
            end else begin
                m_cnt_a++; a_pend = 1'b0;
            end
        end else if (m_valid && rdy) begin
            m_valid = 1'b0;
        end
        @(negedge clk);
        check("out_valid", 64'(out_valid), 64'(m_valid));
        check("out_data", 64'(out_data), 64'(m_data));
        check("out_src", 64'(out_src), 64'(m_src));
        check("cnt_a", 64'(cnt_a), 64'(m_cnt_a % 65536));
        check("cnt_b", 64'(cnt_b), 64'(m_cnt_b % 65536));
        check("out_valid4", 64'(out_valid4), 64'(m_valid));
        check("out_data4", 64'({out_src4, out_data4}), 64'({m_src, m_data}));
        check("cnt_a4", 64'(cnt_a4), 64'(m_cnt_a % 16));
        check("cnt_b4", 64'(cnt_b4), 64'(m_cnt_b % 16));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] held;
        a_pend = 1'b0; b_pend = 1'b0; a_word = '0; b_word = '0;
        a_data = '0; b_data = '0;
        do_reset(2);

        // Widening of all-ones words
        present_a(16'hffff);
        run_cycle(1'b1);
`ifdef WIDTH_ARB_SIGN_EXT_EN
        check("widen_a", 64'(out_data), 64'(32'hffffffff));
`else
        check("widen_a", 64'(out_data), 64'(32'h0000ffff));
`endif
        check("widen_a_src", 64'(out_src), 64'(0));
        check("widen_a_cnt", 64'(cnt_a), 64'(1));
        present_b(25'h1ffffff);
        run_cycle(1'b1);
`ifdef WIDTH_ARB_SIGN_EXT_EN
        check("widen_b", 64'(out_data), 64'(32'hffffffff));
`else
        check("widen_b", 64'(out_data), 64'(32'h01ffffff));
`endif
        check("widen_b_src", 64'(out_src), 64'(1));
        run_cycle(1'b1);

        // Fair alternation from reset
        do_reset(1);
        for (int i = 0; i < 8; i++) begin
            present_a(16'($urandom));
            present_b(25'($urandom));
            run_cycle(1'b1);
            check("alt_src", 64'(out_src), 64'(i % 2));
            check("alt_valid", 64'(out_valid), 64'(1));
        end
        check("alt_cnt_a", 64'(cnt_a), 64'(4));
        check("alt_cnt_b", 64'(cnt_b), 64'(4));

        // Single requester, then both: A goes first
        a_pend = 1'b0;
        b_pend = 1'b0;
        for (int i = 0; i < 3; i++) begin
            present_b(25'($urandom));
            run_cycle(1'b1);
            check("single_b_src", 64'(out_src), 64'(1));
        end
        present_a(16'($urandom));
        present_b(25'($urandom));
        run_cycle(1'b1);
        check("after_b_src", 64'(out_src), 64'(0));
        run_cycle(1'b1);

        // Backpressure: output held for 5 cycles, then the pending winner loads
        run_cycle(1'b1);
        present_a(16'h8123);
        present_b(25'($urandom));
        run_cycle(1'b0);
        held = wa(16'h8123);
        for (int i = 0; i < 5; i++) begin
            present_a(16'($urandom));
            run_cycle(1'b0);
            check("bp_hold", 64'(out_data), 64'(held));
        end
        run_cycle(1'b1);
        check("bp_release_src", 64'(out_src), 64'(1));

        // Reset while a word is held
        present_a(16'($urandom));
        run_cycle(1'b0);
        check("pre_rst_valid", 64'(out_valid), 64'(1));
        do_reset(1);

        // Counter wrap on the 4-bit instance
        for (int i = 0; i < 17; i++) begin
            present_a(16'($urandom));
            run_cycle(1'b1);
        end
        check("wrap_cnt_a4", 64'(cnt_a4), 64'(1));
        check("wrap_cnt_a", 64'(cnt_a), 64'(17));

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) != 0) present_a(16'($urandom));
            if ($urandom_range(0, 3) != 0) present_b(25'($urandom));
            run_cycle($urandom_range(0, 3) != 0);
        end
        while (a_pend || b_pend || m_valid) begin
            run_cycle(1'b1);
        end
        check("final_q_empty", 64'(exp_q.size()), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
